// File: rtl/escape_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : escape_pkg
//  Description : Shared encodings for the maze-escape host: directions, cell
//                types, FSM states, error-bit positions, cell indexing.
//  Revision    : 1.0  initial release
// ============================================================================
package escape_pkg;

    localparam int MAP_DIM   = 17;
    localparam int MAP_CELLS = MAP_DIM * MAP_DIM;
    localparam int MAX_HOST  = 4;

    localparam logic [2:0] DIR_R     = 3'd0;
    localparam logic [2:0] DIR_D     = 3'd1;
    localparam logic [2:0] DIR_L     = 3'd2;
    localparam logic [2:0] DIR_U     = 3'd3;
    localparam logic [2:0] DIR_STALL = 3'd4;

    localparam logic [1:0] CELL_WALL = 2'd0;
    localparam logic [1:0] CELL_PATH = 2'd1;
    localparam logic [1:0] CELL_TRAP = 2'd2;
    localparam logic [1:0] CELL_HOST = 2'd3;

    localparam int ERR_WALL    = 0;
    localparam int ERR_BOUND   = 1;
    localparam int ERR_TRAP    = 2;
    localparam int ERR_TIMEOUT = 3;
    localparam int ERR_PROTO   = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND    = 3'd1,
        S_WALK    = 3'd2,
        S_RESP    = 3'd3,
        S_COLLECT = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    // Raster index of cell (x = column, y = row).
    function automatic logic [8:0] cell_idx(input logic [4:0] x, input logic [4:0] y);
        return ({4'd0, y} * 9'(MAP_DIM)) + {4'd0, x};
    endfunction

endpackage
`default_nettype wire

// File: rtl/escape_pos_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : escape_pos_tracker
//  Description : Engine position register with step, bounds, wall and trap
//                checks. The target cell value is looked up by the parent.
//  Revision    : 1.0  initial release
// ============================================================================
module escape_pos_tracker
    import escape_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       step,
    input  logic [2:0] dir,
    input  logic [1:0] tgt_cell,
    output logic [8:0] pos_idx,
    output logic [8:0] tgt_idx,
    output logic       err_wall,
    output logic       err_bound,
    output logic       err_trap
);

    localparam logic [4:0] EDGE = 5'(MAP_DIM - 1);

    logic [4:0] x_q, x_d, y_q, y_d, nx, ny;
    logic       trap_q, trap_d;
    logic       off_grid, bad_dir, moved;

    // Candidate position for the current direction and its validity.
    always_comb begin
        nx       = x_q;
        ny       = y_q;
        off_grid = 1'b0;
        bad_dir  = 1'b0;
        case (dir)
            DIR_R:     if (x_q == EDGE)  off_grid = 1'b1; else nx = x_q + 5'd1;
            DIR_D:     if (y_q == EDGE)  off_grid = 1'b1; else ny = y_q + 5'd1;
            DIR_L:     if (x_q == 5'd0)  off_grid = 1'b1; else nx = x_q - 5'd1;
            DIR_U:     if (y_q == 5'd0)  off_grid = 1'b1; else ny = y_q - 5'd1;
            DIR_STALL: bad_dir = 1'b0;
            default:   bad_dir = 1'b1;
        endcase
    end

    assign moved     = step && !off_grid && !bad_dir && (dir != DIR_STALL);
    assign err_bound = step && (off_grid || bad_dir);
    assign err_wall  = moved && (tgt_cell == CELL_WALL);
    // A trap must be followed by a stall before the engine may move on.
    assign err_trap  = step && trap_q && (dir != DIR_STALL);
    assign tgt_idx   = cell_idx(nx, ny);
    assign pos_idx   = cell_idx(x_q, y_q);

    // Next position and pending-trap flag.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        trap_d = trap_q;
        if (clear) begin
            x_d    = 5'd0;
            y_d    = 5'd0;
            trap_d = 1'b0;
        end else if (moved) begin
            x_d    = nx;
            y_d    = ny;
            trap_d = (tgt_cell == CELL_TRAP);
        end else if (step && dir == DIR_STALL) begin
            trap_d = 1'b0;
        end
    end

    // Position state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= 5'd0;
            y_q    <= 5'd0;
            trap_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            trap_q <= trap_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/escape_host.sv
`default_nettype none
// ============================================================================
//  Module      : escape_host
//  Description : Host-side driver/monitor for the maze-escape engine: streams
//                the maze, follows the step stream, answers hostage arrivals
//                with passwords and collects the result burst.
//  Revision    : 1.0  initial release
// ============================================================================
module escape_host
    import escape_pkg::*;
#(
    parameter int RESP_DLY = 2,
    parameter int TIMEOUT  = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [8:0]  cfg_addr,
    input  logic [1:0]  cfg_data,
    input  logic        pw_we,
    input  logic [1:0]  pw_idx,
    input  logic [8:0]  pw_data,
    input  logic        start,
    output logic        tx_valid1,
    output logic [1:0]  tx_map,
    output logic        tx_valid2,
    output logic [8:0]  tx_data,
    input  logic        rx_valid2,
    input  logic [2:0]  rx_dir,
    input  logic        rx_valid1,
    input  logic [8:0]  rx_data,
    output logic        busy,
    output logic        done,
    output logic [4:0]  err,
    output logic [9:0]  step_cnt,
    output logic [35:0] result
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [1:0]      map_mem [MAP_CELLS];
    logic [8:0]      pw_mem  [MAX_HOST];

    state_t          state_q, state_d;
    logic [8:0]      cnt_q, cnt_d, hcnt_q, hcnt_d, beat_q, beat_d;
    logic [8:0]      host_q [MAX_HOST];
    logic [8:0]      host_d [MAX_HOST];
    logic [2:0]      k_q, k_d;
    logic [3:0]      dly_q, dly_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            v1p_q, v2p_q;
    logic            tx_valid1_q, tx_valid1_d, tx_valid2_q, tx_valid2_d;
    logic [1:0]      tx_map_q, tx_map_d;
    logic [8:0]      tx_data_q, tx_data_d;
    logic [4:0]      err_q, err_d;
    logic [9:0]      step_q, step_d;
    logic [35:0]     result_q, result_d;

    logic [8:0]      pos_idx, tgt_idx, exp_beats;
    logic [2:0]      heff;
    logic            trk_wall, trk_bound, trk_trap, start_acc;

    assign start_acc = (state_q == S_IDLE) && start;
    // Hostages beyond MAX_HOST are walked over as plain path cells.
    assign heff      = (hcnt_q > 9'(MAX_HOST)) ? 3'(MAX_HOST) : hcnt_q[2:0];
    assign exp_beats = (hcnt_q == 9'd0) ? 9'd1 : hcnt_q;

    escape_pos_tracker u_trk (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_acc),
        .step      ((state_q == S_WALK) && rx_valid2),
        .dir       (rx_dir),
        .tgt_cell  (map_mem[tgt_idx]),
        .pos_idx   (pos_idx),
        .tgt_idx   (tgt_idx),
        .err_wall  (trk_wall),
        .err_bound (trk_bound),
        .err_trap  (trk_trap)
    );

    // Maze and password storage: writable only while idle, survives reset.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && cfg_we && cfg_addr < 9'(MAP_CELLS))
            map_mem[cfg_addr] <= cfg_data;
        if (state_q == S_IDLE && pw_we)
            pw_mem[pw_idx] <= pw_data;
    end

    // Run sequencing: next state, stream outputs, error flags and counters.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        host_d      = host_q;
        beat_d      = beat_q;
        k_d         = k_q;
        dly_d       = dly_q;
        to_d        = to_q;
        tx_valid1_d = 1'b0;
        tx_map_d    = tx_map_q;
        tx_valid2_d = 1'b0;
        tx_data_d   = tx_data_q;
        err_d       = err_q | {2'b00, trk_trap, trk_bound, trk_wall};
        step_d      = step_q;
        result_d    = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_SEND;
                    cnt_d       = 9'd0;
                    hcnt_d      = 9'd0;
                    beat_d      = 9'd0;
                    k_d         = 3'd0;
                    err_d       = 5'd0;
                    step_d      = 10'd0;
                    result_d    = 36'd0;
                    tx_valid1_d = 1'b1;
                    tx_map_d    = map_mem[0];
                end
            end
            S_SEND: begin
                // tx_map_q holds map[cnt_q] this cycle.
                if (tx_map_q == CELL_HOST) begin
                    if (hcnt_q < 9'(MAX_HOST))
                        host_d[hcnt_q[1:0]] = cnt_q;
                    hcnt_d = hcnt_q + 9'd1;
                end
                if (cnt_q == 9'(MAP_CELLS - 1)) begin
                    state_d = S_WALK;
                    if (hcnt_d > 9'(MAX_HOST))
                        err_d[ERR_PROTO] = 1'b1;
                end else begin
                    cnt_d       = cnt_q + 9'd1;
                    tx_valid1_d = 1'b1;
                    tx_map_d    = map_mem[cnt_d];
                end
            end
            S_WALK: begin
                if (rx_valid2 && step_q != 10'h3FF)
                    step_d = step_q + 10'd1;
                if (rx_valid1)
                    err_d[ERR_PROTO] = 1'b1;
                if (v2p_q && !rx_valid2) begin
                    if (k_q < heff && pos_idx == host_q[k_q[1:0]]) begin
                        state_d = S_RESP;
                        dly_d   = 4'd0;
                    end else if (k_q == heff && pos_idx == 9'(MAP_CELLS - 1)) begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_RESP: begin
                if (dly_q == 4'(RESP_DLY - 1)) begin
                    tx_valid2_d = 1'b1;
                    tx_data_d   = pw_mem[k_q[1:0]];
                    k_d         = k_q + 3'd1;
                    state_d     = S_WALK;
                end else begin
                    dly_d = dly_q + 4'd1;
                end
            end
            S_COLLECT: begin
                if (rx_valid2)
                    err_d[ERR_PROTO] = 1'b1;
                if (rx_valid1) begin
                    case (beat_q)
                        9'd0:    result_d[8:0]   = rx_data;
                        9'd1:    result_d[17:9]  = rx_data;
                        9'd2:    result_d[26:18] = rx_data;
                        9'd3:    result_d[35:27] = rx_data;
                        default: result_d        = result_q;
                    endcase
                    if (beat_q != 9'h1FF)
                        beat_d = beat_q + 9'd1;
                end
                if (v1p_q && !rx_valid1) begin
                    if (beat_q != exp_beats)
                        err_d[ERR_PROTO] = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_WALK || state_q == S_RESP || state_q == S_COLLECT) &&
            to_q == TO_W'(TIMEOUT)) begin
            err_d[ERR_TIMEOUT] = 1'b1;
            state_d            = S_FIN;
        end

        if (state_d != state_q || rx_valid1 || rx_valid2)
            to_d = '0;
        else if (to_q != TO_W'(TIMEOUT))
            to_d = to_q + TO_W'(1);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 9'd0;
            hcnt_q      <= 9'd0;
            beat_q      <= 9'd0;
            for (int i = 0; i < MAX_HOST; i++) host_q[i] <= 9'd0;
            k_q         <= 3'd0;
            dly_q       <= 4'd0;
            to_q        <= '0;
            v1p_q       <= 1'b0;
            v2p_q       <= 1'b0;
            tx_valid1_q <= 1'b0;
            tx_map_q    <= 2'd0;
            tx_valid2_q <= 1'b0;
            tx_data_q   <= 9'd0;
            err_q       <= 5'd0;
            step_q      <= 10'd0;
            result_q    <= 36'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            beat_q      <= beat_d;
            host_q      <= host_d;
            k_q         <= k_d;
            dly_q       <= dly_d;
            to_q        <= to_d;
            v1p_q       <= rx_valid1;
            v2p_q       <= rx_valid2;
            tx_valid1_q <= tx_valid1_d;
            tx_map_q    <= tx_map_d;
            tx_valid2_q <= tx_valid2_d;
            tx_data_q   <= tx_data_d;
            err_q       <= err_d;
            step_q      <= step_d;
            result_q    <= result_d;
        end
    end

    assign tx_valid1 = tx_valid1_q;
    assign tx_map    = tx_map_q;
    assign tx_valid2 = tx_valid2_q;
    assign tx_data   = tx_data_q;
    assign busy      = (state_q == S_SEND) || (state_q == S_WALK) ||
                       (state_q == S_RESP) || (state_q == S_COLLECT);
    assign done      = (state_q == S_FIN);
    assign err       = err_q;
    assign step_cnt  = step_q;
    assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_escape_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_escape_host
//  Description : Directed self-checking bench for escape_host.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_escape_host;
    import escape_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0, pw_we = 1'b0, start = 1'b0;
    logic [8:0]  cfg_addr = 9'd0, pw_data = 9'd0, rx_data = 9'd0;
    logic [1:0]  cfg_data = 2'd0, pw_idx = 2'd0;
    logic        rx_valid1 = 1'b0, rx_valid2 = 1'b0;
    logic [2:0]  rx_dir = 3'd0;
    logic        tx_valid1, tx_valid2, busy, done;
    logic [1:0]  tx_map;
    logic [8:0]  tx_data;
    logic [4:0]  err;
    logic [9:0]  step_cnt;
    logic [35:0] result;

    int          tests = 0;
    int          failed = 0;
    logic [1:0]  exp_map [MAP_CELLS];

    escape_host dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .pw_we(pw_we), .pw_idx(pw_idx), .pw_data(pw_data), .start(start),
        .tx_valid1(tx_valid1), .tx_map(tx_map), .tx_valid2(tx_valid2), .tx_data(tx_data),
        .rx_valid2(rx_valid2), .rx_dir(rx_dir), .rx_valid1(rx_valid1), .rx_data(rx_data),
        .busy(busy), .done(done), .err(err), .step_cnt(step_cnt), .result(result)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [1:0] v);
        for (int i = 0; i < MAP_CELLS; i++) begin
            cfg_we = 1'b1; cfg_addr = 9'(i); cfg_data = v; exp_map[i] = v;
            tick;
        end
        cfg_we = 1'b0;
    endtask

    task automatic set_cell(input int idx, input logic [1:0] v);
        cfg_we = 1'b1; cfg_addr = 9'(idx); cfg_data = v; exp_map[idx] = v;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic set_pw(input logic [1:0] idx, input logic [8:0] v);
        pw_we = 1'b1; pw_idx = idx; pw_data = v;
        tick;
        pw_we = 1'b0;
    endtask

    // Start a run and check the full map stream; optionally poke config/start mid-stream.
    task automatic run_send(input string tag, input bit meddle);
        int n;
        int bad;
        start = 1'b1; tick; start = 1'b0;
        n = 0; bad = 0;
        while (tx_valid1 && n < 400) begin
            if (n >= MAP_CELLS || tx_map !== exp_map[n]) bad++;
            if (meddle && n == 3) begin
                cfg_we = 1'b1; cfg_addr = 9'd288; cfg_data = CELL_WALL; start = 1'b1;
                pw_we = 1'b1; pw_idx = 2'd0; pw_data = 9'h1FF;
            end else begin
                cfg_we = 1'b0; start = 1'b0; pw_we = 1'b0;
            end
            n++;
            tick;
        end
        chk({tag, "_beats"}, 64'(n), 64'd289);
        chk({tag, "_map"}, 64'(bad), 64'd0);
    endtask

    task automatic steps(input logic [2:0] dir, input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid2 = 1'b1; rx_dir = dir;
            tick;
        end
    endtask

    task automatic drop;
        rx_valid2 = 1'b0; rx_dir = 3'd0;
        tick;
    endtask

    // Called one cycle after the fall has been seen.
    task automatic resp(input string tag, input logic [8:0] pw);
        chk({tag, "_gap1"}, 64'(tx_valid2), 64'd0);
        tick;
        chk({tag, "_gap2"}, 64'(tx_valid2), 64'd0);
        tick;
        chk({tag, "_pulse"}, 64'({tx_valid2, tx_data}), 64'({1'b1, pw}));
        tick;
        chk({tag, "_end"}, 64'(tx_valid2), 64'd0);
    endtask

    task automatic collect(input string tag, input int n, input logic [8:0] base);
        for (int i = 0; i < n; i++) begin
            rx_valid1 = 1'b1; rx_data = base + 9'(i);
            tick;
        end
        rx_valid1 = 1'b0; rx_data = 9'd0;
        tick;
        chk({tag, "_done"}, 64'(done), 64'd1);
        tick;
        chk({tag, "_idle"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        int c;
        tick; tick;
        chk("rst_outs", 64'({tx_valid1, tx_map, tx_valid2, tx_data, busy, done, err, step_cnt}), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        rst = 1'b0;
        tick;

        // Open map, no hostages.
        fill(CELL_PATH);
        run_send("t1", 1'b0);
        chk("t1_busy", 64'(busy), 64'd1);
        steps(DIR_R, 16); steps(DIR_D, 16); drop;
        chk("t1_collect_busy", 64'({busy, done}), 64'b10);
        collect("t1", 1, 9'h0A5);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_steps", 64'(step_cnt), 64'd32);
        chk("t1_res", 64'(result[8:0]), 64'h0A5);

        // One hostage at row 0, column 5.
        set_cell(5, CELL_HOST);
        set_pw(2'd0, 9'h045);
        run_send("t2", 1'b0);
        steps(DIR_R, 5); drop;
        resp("t2", 9'h045);
        steps(DIR_R, 11); steps(DIR_D, 16); drop;
        collect("t2", 1, 9'h155);
        chk("t2_err", 64'(err), 64'd0);
        chk("t2_steps", 64'(step_cnt), 64'd32);
        chk("t2_res", 64'(result[8:0]), 64'h155);

        // Trap at column 1 left without stalling, then with a stall.
        set_cell(5, CELL_PATH);
        set_cell(1, CELL_TRAP);
        run_send("t3a", 1'b0);
        steps(DIR_R, 16); steps(DIR_D, 16); drop;
        collect("t3a", 1, 9'h011);
        chk("t3a_err", 64'(err), 64'b00100);
        run_send("t3b", 1'b0);
        steps(DIR_R, 1); steps(DIR_STALL, 1); steps(DIR_R, 15); steps(DIR_D, 16); drop;
        collect("t3b", 1, 9'h012);
        chk("t3b_err", 64'(err), 64'd0);
        chk("t3b_steps", 64'(step_cnt), 64'd33);

        // Off-grid left from the origin, then into a wall.
        set_cell(1, CELL_WALL);
        run_send("t4", 1'b0);
        steps(DIR_L, 1); steps(DIR_R, 16); steps(DIR_D, 16); drop;
        collect("t4", 1, 9'h013);
        chk("t4_err", 64'(err), 64'b00011);
        chk("t4_steps", 64'(step_cnt), 64'd33);

        // Silent engine after the map stream.
        run_send("t5", 1'b0);
        c = 0;
        while (!done && c < 3200) begin
            tick;
            c++;
        end
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_latency", 64'(c >= 2998 && c <= 3004), 64'd1);
        chk("t5_err", 64'(err), 64'b01000);
        tick;
        chk("t5_idle", 64'(busy), 64'd0);

        // Three hostages, short result burst.
        set_cell(1, CELL_PATH);
        set_cell(2, CELL_HOST); set_cell(4, CELL_HOST); set_cell(6, CELL_HOST);
        set_pw(2'd0, 9'h101); set_pw(2'd1, 9'h0A3); set_pw(2'd2, 9'h1C7);
        run_send("t6", 1'b0);
        steps(DIR_R, 2); drop; resp("t6a", 9'h101);
        steps(DIR_R, 2); drop; resp("t6b", 9'h0A3);
        steps(DIR_R, 2); drop; resp("t6c", 9'h1C7);
        steps(DIR_R, 10); steps(DIR_D, 16); drop;
        collect("t6", 2, 9'h033);
        chk("t6_err", 64'(err), 64'b10000);
        chk("t6_res", 64'(result[17:0]), 64'({9'h034, 9'h033}));

        // Reset in the middle of the map stream, then restream.
        start = 1'b1; tick; start = 1'b0;
        repeat (20) tick;
        chk("t7_mid", 64'(tx_valid1), 64'd1);
        rst = 1'b1;
        #1;
        chk("t7_rst", 64'({tx_valid1, tx_map, busy}), 64'd0);
        rst = 1'b0;
        tick;
        run_send("t7", 1'b1);
        chk("t7_walk_busy", 64'(busy), 64'd1);
        rst = 1'b1; tick; rst = 1'b0; tick;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/escape_host.md
Name: escape_host

Overview:
- Host-side driver/monitor for the maze-escape engine's serial interface.
- Streams a preloaded 17x17 maze (row-major) to the engine. Follows the engine's step stream and tracks its position, answering each hostage arrival with a preloaded excess-3 password. Then collects the final result burst.
- Flags protocol and path violations. Serves as the engine's stimulus/checker block in system integration and in the bench.

Parameters:
- MAP_DIM, 17, maze side length; cells = MAP_DIM*MAP_DIM = 289
- MAX_HOST, 4, maximum hostages supported
- RESP_DLY, 2, idle cycles between rx_valid2 falling and the tx_valid2 pulse
- TIMEOUT, 3000, maximum cycles allowed in any wait state before a timeout error

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  maze cell write strobe (IDLE only; ignored otherwise)
- cfg_addr  in  9  cell index y*17+x, 0..288; writes to 289..511 are ignored
- cfg_data  in  2  0 wall, 1 path, 2 trap, 3 hostage
- pw_we  in  1  password write strobe (IDLE only)
- pw_idx  in  2  hostage ordinal, in raster order
- pw_data  in  9  excess-3 password, bit8 = sign
- start  in  1  one-cycle pulse; accepted in IDLE only
- tx_valid1  out  1  map stream valid
- tx_map  out  2  map cell value
- tx_valid2  out  1  password valid (single-cycle pulse)
- tx_data  out  9  password
- rx_valid2  in  1  engine step valid
- rx_dir  in  3  0 right, 1 down, 2 left, 3 up, 4 stall
- rx_valid1  in  1  engine result valid
- rx_data  in  9  engine result word
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse at end of run
- err  out  5  sticky error flags, cleared on start
- step_cnt  out  10  number of accepted rx_valid2 beats
- result  out  36  four 9-bit collected words; word i in bits [9i+8:9i]

Behaviour:
- Reset values: all outputs 0; position (0,0); FSM in IDLE. Map/password storage is not reset.
- States and transitions:
  - IDLE -> SEND on start.
  - SEND: 289 cycles. tx_valid1=1 and tx_map=map[cnt], cnt 0..288, registered output, first beat the cycle after start. Hostage cells are counted (hcnt) and their positions latched in raster order. Exits to WALK.
  - WALK: each rx_valid2 beat updates position per rx_dir and increments step_cnt (saturates at 1023).
    - Wall cell entered -> err[0].
    - Step off grid -> err[1]; position is not updated.
    - Previous cell was a trap and rx_dir != 4 -> err[2].
    - rx_dir 5..7 -> err[1].
  - WALK -> RESP when rx_valid2 falls while position == hostage[k], k < hcnt.
  - RESP: waits RESP_DLY cycles, then asserts tx_valid2 for exactly 1 cycle with tx_data=pw[k]; k++ -> WALK.
  - WALK -> COLLECT when rx_valid2 falls at (16,16) with k == hcnt.
  - COLLECT: stores rx_data into result word j on each rx_valid1 beat; expected beats = max(hcnt,1). When rx_valid1 falls, a count mismatch sets err[4]. -> FIN.
  - FIN: done=1 for 1 cycle, busy=0 -> IDLE.
- hcnt > MAX_HOST -> err[4] at end of SEND. The run continues; only the first 4 passwords are used and the extra hostages are treated as path cells.
- Timeout counter resets on any rx_valid1/rx_valid2 activity or state change. If it reaches TIMEOUT in WALK, RESP or COLLECT -> err[3], go to FIN.
- rx_valid1 during WALK or rx_valid2 during COLLECT -> err[4]; the beat is ignored.
- start while busy is ignored. cfg_we/pw_we while busy are ignored.
- Async rst mid-run: every output returns to 0 within the same cycle; map and passwords are retained.
- err bits are sticky until the next accepted start.

Decomposition:
- Package escape_pkg: direction encodings (DIR_R/D/L/U/STALL), cell encodings (CELL_WALL/PATH/TRAP/HOST), FSM state enum, MAP_DIM, error-bit indices.
- One sub-module: escape_pos_tracker. Holds the position register and implements the step, bounds, wall and trap checks against a cell-lookup input.

Test Plan:
- All-path map, no hostages, engine sends 32 steps (16 right, 16 down) then one rx_valid1 beat of 0 -> 289 tx_valid1 beats; done; step_cnt=32; err=0; result[8:0]=0.
- One hostage at (0,5), pw=9'h045: engine steps right 5 times, drops rx_valid2 -> tx_valid2 exactly 3 cycles after the fall, tx_data=9'h045; walk then resumes.
- Trap at (0,1): engine sends right then right (no stall) -> err[2]=1. Repeat with right, stall, right -> err=0.
- Engine steps into a wall cell -> err[0]=1, run still completes; a step left from (0,0) -> err[1]=1 and position stays (0,0).
- Engine stops responding after SEND -> err[3] set after TIMEOUT cycles, then done pulse, busy=0.
- Three hostages but engine returns 2 result beats -> err[4]=1. Also pulse rst mid-SEND -> tx_valid1=0 immediately, IDLE, and a re-start streams the same map.
